// File: rtl/ucsbece154b_icache.sv
// Direct-mapped instruction cache for the fetch stage.
// A miss stalls the core (ReadyF low), requests the whole line from the
// burst memory, fills it word by word, then lookup resumes in IDLE.
// Hit and miss counters are exported for prefetcher evaluation.
module ucsbece154b_icache #(
    parameter int NUM_SETS    = 8,
    parameter int BLOCK_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic        ReadEnable,
    input  logic        Flush,
    output logic [31:0] InstrF,
    output logic        ReadyF,
    output logic        MemReadRequest,
    output logic [31:0] MemReadAddress,
    input  logic [31:0] MemDataIn,
    input  logic        MemDataReady,
    output logic [31:0] HitCount,
    output logic [31:0] MissCount
);

    localparam int OB = $clog2(BLOCK_WORDS);
    localparam int IB = $clog2(NUM_SETS);
    localparam int TB = 32 - 2 - OB - IB;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [OB-1:0] LAST_WORD = OB'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL
    } state_t;

    state_t          state_q;
    logic [31:0]     data_q [NUM_SETS][BLOCK_WORDS];
    logic [TB-1:0]   tag_q  [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q;

    logic [IB-1:0]   fill_idx_q;
    logic [TB-1:0]   fill_tag_q;
    logic [OB-1:0]   cnt_q;
    logic            mem_req_q;
    logic [31:0]     mem_addr_q;
    logic [31:0]     hit_cnt_q;
    logic [31:0]     miss_cnt_q;

    logic [OB-1:0]   pc_off;
    logic [IB-1:0]   pc_idx;
    logic [TB-1:0]   pc_tag;
    logic            hit;

    assign pc_off = PCF[2+OB-1:2];
    assign pc_idx = PCF[2+OB+IB-1:2+OB];
    assign pc_tag = PCF[31:2+OB+IB];

    // Lookup is only answered in IDLE; during REQ/FILL the core stays stalled
    // even if PCF happens to point at another valid line.
    assign hit    = (state_q == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign ReadyF = hit;
    assign InstrF = hit ? data_q[pc_idx][pc_off] : NOP;

    assign MemReadRequest = mem_req_q;
    assign MemReadAddress = mem_addr_q;
    assign HitCount       = hit_cnt_q;
    assign MissCount      = miss_cnt_q;

    // Byte-offset bits are never used, and a flush needs no action: an
    // in-flight fill always completes because memory cannot cancel it, and
    // IDLE simply looks up whatever PCF the core presents afterwards.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, PCF[1:0], Flush};

    // Data and tag storage: written by fill beats only.
    // NOTE: the arrays carry no reset; valid_q alone decides whether a line
    // is usable, so resetting storage would only cost flops.
    always_ff @(posedge clk) begin
        if (state_q == FILL && MemDataReady) begin
            data_q[fill_idx_q][cnt_q] <= MemDataIn;
            if (cnt_q == LAST_WORD) begin
                tag_q[fill_idx_q] <= fill_tag_q;
            end
        end
    end

    // Control FSM with registered memory request, valid bits and counters.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            fill_idx_q <= '0;
            fill_tag_q <= '0;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!hit) begin
                        // A miss starts even while the core is stalled.
                        fill_idx_q <= pc_idx;
                        fill_tag_q <= pc_tag;
                        mem_addr_q <= {PCF[31:2+OB], {(OB + 2){1'b0}}};
                        mem_req_q  <= 1'b1;
                        miss_cnt_q <= miss_cnt_q + 32'd1;
                        state_q    <= REQ;
                    end else if (ReadEnable) begin
                        hit_cnt_q <= hit_cnt_q + 32'd1;
                    end
                end
                REQ: begin
                    mem_req_q           <= 1'b0;
                    valid_q[fill_idx_q] <= 1'b0;
                    cnt_q               <= '0;
                    state_q             <= FILL;
                end
                FILL: begin
                    if (MemDataReady) begin
                        if (cnt_q == LAST_WORD) begin
                            valid_q[fill_idx_q] <= 1'b1;
                            cnt_q               <= '0;
                            state_q             <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + OB'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
